simple_ram: RTL and testbench
=============================

SIMPLE_RAM -- requirements
Module: simple_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits; depth = 2**ADDR_W words (256 by default).
REQ-003 clk  input  1  sole clock; all state changes on rising edge except reset.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 we  input  1  write enable; 1 = write cycle, 0 = read cycle.
REQ-006 addr  input  ADDR_W  word address for the read or write.
REQ-007 data_in  input  DATA_W  write data, sampled on a rising clk edge when we=1.
REQ-008 data_out  output  DATA_W  registered read data.

Function
REQ-009 Storage SHALL be a single-port array of 2**ADDR_W words of DATA_W bits, plus one valid bit per word.
REQ-010 Write: on rising clk with rst_n=1 and we=1, mem[addr] SHALL take data_in and valid[addr] SHALL be set to 1.
REQ-011 Read: on rising clk with rst_n=1 and we=0, data_out SHALL take mem[addr] if valid[addr]=1, otherwise all zeros.
REQ-012 Read latency SHALL be exactly one clock: data_out reflects the addr sampled at the previous rising edge.
REQ-013 Write-cycle output (macro absent): data_out SHALL take the pre-write contents of mem[addr] (read-first); this is zero if the word was never written.
REQ-014 data_out SHALL hold its value between rising edges; it SHALL NOT change combinationally with addr, we or data_in.
REQ-015 Address range: every value of addr is legal; no wrap-around or out-of-range condition exists.
REQ-016 Back-to-back writes to consecutive or identical addresses SHALL each complete in one cycle, with the last write winning.
REQ-017 A read of an address in the cycle immediately after a write to that address SHALL return the newly written data.
REQ-018 Unknown or unwritten storage SHALL never propagate to data_out; the valid bits guarantee a zero result.

Reset
REQ-019 While rst_n=0: data_out SHALL be 0 immediately, independent of clk.
REQ-020 While rst_n=0: all valid bits SHALL be cleared.
REQ-021 While rst_n=0: writes SHALL be ignored.
REQ-022 Array contents need not be cleared by reset; after reset every word SHALL still read as 0 through the valid bits.
REQ-023 Reset asserted mid-operation SHALL abort any write in progress; after release, all addresses SHALL read 0 until they are rewritten.
REQ-024 Normal operation SHALL resume at the first rising clk edge after rst_n returns to 1.

Configuration
REQ-025 Macro SIMPLE_RAM_WRITE_THROUGH_EN, when defined, SHALL make write cycles load data_out with data_in (write-first) instead of the old contents.
REQ-026 When SIMPLE_RAM_WRITE_THROUGH_EN is undefined, write cycles SHALL behave read-first per REQ-013; all other behaviour is identical in both builds.

Verification
REQ-027 Fill and read back: write 00<-A5, 01<-3C, 02<-F0, 03<-55 on consecutive cycles, then read 00..03 -> data_out A5, 3C, F0, 55, each one cycle after its address.
REQ-028 Unwritten address: after reset, read 04 -> data_out 00.
REQ-029 Overwrite (macro absent): write 01<-99 -> data_out 3C during that cycle; then read 01 -> 99.
REQ-030 Overwrite (SIMPLE_RAM_WRITE_THROUGH_EN defined): write 01<-99 -> data_out 99 in the write cycle.
REQ-031 Reset mid-stream: write 02<-F0, pulse rst_n low between clock edges -> data_out 00 at once; then read 02 -> 00.
REQ-032 Ignored write under reset: hold rst_n=0 with we=1, addr 05, data_in 77; release, then read 05 -> 00.

Source files
------------

// File: rtl/simple_ram.sv
// simple_ram: single-port synchronous RAM with a per-word valid bit.
// Reads and writes take one clock; data_out is registered and only
// ever shows contents of words written since the last reset, so
// uninitialised storage never reaches the output.
//
// Build option: define SIMPLE_RAM_WRITE_THROUGH_EN to make write cycles
// load data_out with data_in (write-first). Without it, write cycles
// return the word's previous contents (read-first).
//
// Handshake: none. Every rising clk edge with rst_n=1 is one access;
// we=1 writes addr, we=0 reads addr, and data_out is valid one clock later.
module simple_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage array is deliberately not reset; the valid bits stand in for it.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Contents of the addressed word as seen before this edge, masked to zero
    // when the word has not been written since reset.
    logic [DATA_W-1:0] stored_word;

    // Masked read of the addressed word.
    always_comb begin
        stored_word = '0;
        if (valid[addr]) begin
            stored_word = mem[addr];
        end
    end

    // Array write; gated by rst_n so writes presented during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= data_in;
        end
    end

    // Valid bits: cleared asynchronously by reset, set by each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[addr] <= 1'b1;
        end
    end

    // Registered output: zero in reset, otherwise read data or write-cycle data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (we) begin
`ifdef SIMPLE_RAM_WRITE_THROUGH_EN
            data_out <= data_in;
`else
            data_out <= stored_word;
`endif
        end else begin
            data_out <= stored_word;
        end
    end

endmodule

// File: tb/tb_simple_ram.sv
// Directed testbench for simple_ram with hand-computed expected values.
// Inputs change 1 ns after each rising edge; outputs are sampled at that
// same point, well away from the active edge.
module tb_simple_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    int n_compared;
    int n_mismatched;

    simple_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_value(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: data_out=%02h expected=%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected data_out after a write cycle, given the new data and the
    // word's previous (masked) contents.
    function automatic logic [DATA_W-1:0] write_exp(input logic [DATA_W-1:0] new_data,
                                                    input logic [DATA_W-1:0] old_data);
`ifdef SIMPLE_RAM_WRITE_THROUGH_EN
        return new_data;
`else
        return old_data;
`endif
    endfunction

    // Present one access, clock it, and return 1 ns after the edge.
    task automatic drive_cycle(input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
        we      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [DATA_W-1:0] old_data, input string tag);
        drive_cycle(1'b1, a, d);
        check_value(tag, data_out, write_exp(d, old_data));
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                             input string tag);
        drive_cycle(1'b0, a, '0);
        check_value(tag, data_out, exp);
    endtask

    logic [DATA_W-1:0] held;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Reset held with a write presented: it must be ignored.
        rst_n   = 1'b0;
        we      = 1'b1;
        addr    = 8'h05;
        data_in = 8'h77;
        #3;
        check_value("reset_initial", data_out, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_hold_write", data_out, 8'h00);

        // Release between edges; first edge afterwards is a normal access.
        we    = 1'b0;
        rst_n = 1'b1;

        read_word(8'h04, 8'h00, "unwritten_04");
        read_word(8'h05, 8'h00, "ignored_write_05");

        // Fill 00..03 back to back, then read back.
        write_word(8'h00, 8'hA5, 8'h00, "fill_00");
        write_word(8'h01, 8'h3C, 8'h00, "fill_01");
        write_word(8'h02, 8'hF0, 8'h00, "fill_02");
        write_word(8'h03, 8'h55, 8'h00, "fill_03");
        read_word(8'h00, 8'hA5, "read_00");
        read_word(8'h01, 8'h3C, "read_01");
        read_word(8'h02, 8'hF0, "read_02");
        read_word(8'h03, 8'h55, "read_03");

        // Output holds between edges while inputs change.
        held    = data_out;
        addr    = 8'h00;
        we      = 1'b1;
        data_in = 8'hEE;
        #3;
        check_value("hold_between_edges", data_out, 8'h55);
        we = 1'b0;

        // Overwrite, then read immediately after.
        write_word(8'h01, 8'h99, 8'h3C, "overwrite_01");
        read_word(8'h01, 8'h99, "read_after_overwrite_01");

        // Same address twice in a row: last write wins.
        write_word(8'h06, 8'h11, 8'h00, "b2b_first_06");
        write_word(8'h06, 8'h22, 8'h11, "b2b_second_06");
        read_word(8'h06, 8'h22, "b2b_read_06");

        // Address extremes.
        write_word(8'hFF, 8'hC3, 8'h00, "write_ff");
        read_word(8'hFF, 8'hC3, "read_ff");
        read_word(8'h00, 8'hA5, "read_00_again");

        // Reset pulse mid-stream between edges.
        write_word(8'h02, 8'hF0, 8'hF0, "rewrite_02");
        we    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("reset_async_clear", data_out, 8'h00);
        #1;
        rst_n = 1'b1;
        read_word(8'h02, 8'h00, "post_reset_02");
        read_word(8'h01, 8'h00, "post_reset_01");
        read_word(8'hFF, 8'h00, "post_reset_ff");

        // Normal operation after reset.
        write_word(8'h02, 8'h5A, 8'h00, "post_reset_write_02");
        read_word(8'h02, 8'h5A, "post_reset_read_02");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
